// File: rtl/mxu_stream_ctrl.sv
// Streams two 3x3 operand matrices in word by word, captures the external MXU
// product for one cycle, then drains the nine 16-bit result words.
module mxu_stream_ctrl (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [15:0]  in_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         abort,
  output logic [143:0] mxu_a,
  output logic [143:0] mxu_b,
  input  logic [143:0] mxu_out,
  output logic [15:0]  out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {LOAD_A, LOAD_B, CALC, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              run_q;
  logic [8:0][15:0]  a_q, b_q, res_q;
  logic              a_we, b_we, res_we;
  logic              last;

  // run_q keeps in_ready low until the first edge after reset release
  assign in_ready  = run_q && (state_q == LOAD_A || state_q == LOAD_B);
  assign out_valid = (state_q == DRAIN);
  assign out_data  = (state_q == DRAIN) ? res_q[cnt_q] : '0;
  assign busy      = !(state_q == LOAD_A && cnt_q == 4'd0);
  assign mxu_a     = a_q;
  assign mxu_b     = b_q;
  assign last      = (cnt_q == 4'd8);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_we    = 1'b0;
    b_we    = 1'b0;
    res_we  = 1'b0;
    done    = 1'b0;
    if (abort) begin
      state_d = LOAD_A;
      cnt_d   = '0;
    end else begin
      case (state_q)
        LOAD_A: if (in_valid && in_ready) begin
          a_we = 1'b1;
          if (last) begin
            cnt_d   = '0;
            state_d = LOAD_B;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        LOAD_B: if (in_valid && in_ready) begin
          b_we = 1'b1;
          if (last) begin
            cnt_d   = '0;
            state_d = CALC;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        CALC: begin
          res_we  = 1'b1;
          cnt_d   = '0;
          state_d = DRAIN;
        end
        DRAIN: if (out_ready) begin
          if (last) begin
            done    = 1'b1;
            cnt_d   = '0;
            state_d = LOAD_A;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        default: begin
          state_d = LOAD_A;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD_A;
      cnt_q   <= '0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      run_q   <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
    end else begin
      if (a_we)   a_q[cnt_q] <= in_data;
      if (b_we)   b_q[cnt_q] <= in_data;
      if (res_we) res_q      <= mxu_out;
    end
  end

endmodule
